// File: rtl/priority_code_decoder_seq.sv
// Receive end of the 4-line priority encoder link: decodes a 2-bit {W,Y} code into a timed
// one-hot pulse on A..D, followed by a mandatory idle gap, with a one-entry holding register.
module priority_code_decoder_seq #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic W,
    input  logic Y,
    input  logic in_valid,
    output logic in_ready,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_lines, w_lines_nxt;
    logic             r_busy, r_done, w_done_nxt;
    logic             r_hold_valid;
    logic [1:0]       r_hold_code;
    logic             w_take;

    assign in_ready = ~r_hold_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_code  <= '0;
        end else if (w_take) begin
            r_hold_valid <= 1'b0;
        end else if (in_valid && !r_hold_valid) begin
            r_hold_valid <= 1'b1;
            r_hold_code  <= {W, Y};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lines_nxt = r_lines;
        w_take      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hold_valid) begin
                    w_state_nxt = S_PULSE;
                    // code 11 lands on bit 3 (A) down to code 00 on bit 0 (D)
                    w_lines_nxt = 4'b0001 << r_hold_code;
                    w_cnt_nxt   = CNT_W'(PULSE_LEN - 1);
                    w_take      = 1'b1;
                end
            end
            S_PULSE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = S_GAP;
                    w_lines_nxt = '0;
                    w_cnt_nxt   = CNT_W'(GAP_LEN - 1);
                end
            end
            S_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_lines_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
        // done is registered, so it is predicted from the state entering the final PULSE cycle
        w_done_nxt = (w_state_nxt == S_PULSE) && (w_cnt_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lines <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lines <= w_lines_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign A    = r_lines[3];
    assign B    = r_lines[2];
    assign C    = r_lines[1];
    assign D    = r_lines[0];
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_priority_code_decoder_seq.sv
// Bench for priority_code_decoder_seq: two instances (4/1 and 1/3 timing) driven in lockstep and
// checked every cycle against a timeline model of pulse start edges.
module tb_priority_code_decoder_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic W = 1'b0, Y = 1'b0, in_valid = 1'b0;
    logic [1:0] rdy, a, b, c, d, bsy, dn;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    priority_code_decoder_seq #(.PULSE_LEN(4), .GAP_LEN(1), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .W(W), .Y(Y), .in_valid(in_valid), .in_ready(rdy[0]),
        .A(a[0]), .B(b[0]), .C(c[0]), .D(d[0]), .busy(bsy[0]), .done(dn[0])
    );

    priority_code_decoder_seq #(.PULSE_LEN(1), .GAP_LEN(3), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .W(W), .Y(Y), .in_valid(in_valid), .in_ready(rdy[1]),
        .A(a[1]), .B(b[1]), .C(c[1]), .D(d[1]), .busy(bsy[1]), .done(dn[1])
    );

    // Model: a pulse starting at edge s is high after edges s..s+P-1, busy through s+P+G-1,
    // and the next pulse may start no earlier than edge s+P+G+1.
    longint p_len [2] = '{4, 1};
    longint g_len [2] = '{1, 3};
    bit       m_hv  [2];
    logic [1:0] m_hc [2];
    longint   m_ps  [2];
    logic [1:0] m_pc [2];
    longint   m_nxt [2];
    longint   cyc = 0;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got {A,B,C,D,busy,done,rdy}=%b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hv[i]  = 1'b0;
            m_hc[i]  = '0;
            m_ps[i]  = -1000;
            m_pc[i]  = '0;
            m_nxt[i] = 0;
        end
    endtask

    function automatic logic [6:0] expected(input int i, input longint e);
        logic on, bz, dne;
        logic [3:0] lines;
        on    = (e >= m_ps[i]) && (e <= m_ps[i] + p_len[i] - 1);
        bz    = (e >= m_ps[i]) && (e <= m_ps[i] + p_len[i] + g_len[i] - 1);
        dne   = (e == m_ps[i] + p_len[i] - 1);
        lines = 4'd0;
        if (on) begin
            case (m_pc[i])
                2'd3:    lines = 4'b1000;
                2'd2:    lines = 4'b0100;
                2'd1:    lines = 4'b0010;
                default: lines = 4'b0001;
            endcase
        end
        return {lines, bz, dne, ~m_hv[i]};
    endfunction

    function automatic logic [6:0] observed(input int i);
        return {a[i], b[i], c[i], d[i], bsy[i], dn[i], rdy[i]};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "/p4g1"}, observed(0), expected(0, cyc));
        chk({tag, "/p1g3"}, observed(1), expected(1, cyc));
    endtask

    task automatic tick(input string tag, input bit v, input logic [1:0] code);
        in_valid = v;
        {W, Y}   = code;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_hv[i] && cyc >= m_nxt[i]) begin
                    m_ps[i]  = cyc;
                    m_pc[i]  = m_hc[i];
                    m_hv[i]  = 1'b0;
                    m_nxt[i] = cyc + p_len[i] + g_len[i] + 1;
                end else if (v && !m_hv[i]) begin
                    m_hv[i] = 1'b1;
                    m_hc[i] = code;
                end
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset_async");
        tick("reset", 1'b0, 2'd0);
        tick("reset", 1'b0, 2'd0);
        rst_n = 1'b1;

        // single code 11
        tick("code11", 1'b1, 2'd3);
        for (int k = 0; k < 8; k++) tick("code11", 1'b0, 2'd0);

        // 10, 01, 00 each presented once the holding register is free
        for (int k = 2; k >= 0; k--) begin
            for (int g = 0; g < 50 && m_hv[0]; g++) tick("seq_wait", 1'b0, 2'd0);
            tick("seq", 1'b1, 2'(k));
        end
        for (int k = 0; k < 12; k++) tick("seq_drain", 1'b0, 2'd0);

        // continuous valid: 11 then 00 back-to-back
        tick("b2b", 1'b1, 2'd3);
        for (int k = 0; k < 14; k++) tick("b2b", 1'b1, 2'd0);
        for (int k = 0; k < 12; k++) tick("b2b_drain", 1'b0, 2'd0);

        // async reset during the second cycle of a C pulse
        tick("pre_rst", 1'b1, 2'd1);
        tick("pre_rst", 1'b0, 2'd0);
        tick("pre_rst", 1'b0, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        tick("rst_hold", 1'b0, 2'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) tick("post_rst", 1'b0, 2'd0);

        // idle inputs toggling with in_valid low
        for (int k = 0; k < 50; k++) tick("idle_toggle", 1'b0, 2'($urandom_range(3)));

        // back-to-back random codes, then fully random traffic
        for (int k = 0; k < 30; k++) tick("b2b_rand", 1'b1, 2'($urandom_range(3)));
        for (int k = 0; k < 400; k++)
            tick("random", 1'($urandom_range(1)), 2'($urandom_range(3)));
        for (int k = 0; k < 12; k++) tick("final_drain", 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
